rtc_stopwatch: RTL and testbench

Stopwatch/profiler placed directly downstream of the millisecond RTC. It consumes the free-running 32-bit millisecond count and measures how long each image-preprocessing job runs, using start/stop pulses from the pipeline. It keeps last, max and count statistics and runs a per-job timeout watchdog. Results go to the CPU through a simple register port with an interrupt.

---
 rtl/rtc_stopwatch.sv | 156 +++++++++++++++
 tb/tb_rtc_stopwatch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_stopwatch.sv
`default_nettype none
// rtc_stopwatch: job-duration profiler on the ms RTC count with last/max/count
// statistics, per-run timeout watchdog and a register port with interrupt. Rev 1.0
module rtc_stopwatch #(
  parameter int              MS_W        = 32,
  parameter logic [MS_W-1:0] TIMEOUT_RST = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [MS_W-1:0] ms_in,
  input  logic            start,
  input  logic            stop,
  input  logic            cs,
  input  logic            we,
  input  logic [2:0]      addr,
  input  logic [MS_W-1:0] wdata,
  output logic [MS_W-1:0] rdata,
  output logic            irq
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            enable_q, enable_d, irq_en_q, irq_en_d;
  logic            done_q, done_d, tflag_q, tflag_d, fired_q, fired_d;
  logic [MS_W-1:0] start_ts_q, start_ts_d, last_q, last_d, max_q, max_d;
  logic [MS_W-1:0] count_q, count_d, timeout_val_q, timeout_val_d;
  logic [MS_W-1:0] rdata_q, rdata_d;
  logic            irq_q, irq_d;
  logic [MS_W-1:0] elapsed;
  logic            wr, rd, clr;

  always_comb begin
    state_d       = state_q;
    enable_d      = enable_q;
    irq_en_d      = irq_en_q;
    done_d        = done_q;
    tflag_d       = tflag_q;
    fired_d       = fired_q;
    start_ts_d    = start_ts_q;
    last_d        = last_q;
    max_d         = max_q;
    count_d       = count_q;
    timeout_val_d = timeout_val_q;
    rdata_d       = rdata_q;
    wr            = cs & we;
    rd            = cs & ~we;
    clr           = wr && (addr == 3'd0) && wdata[2];
    elapsed       = ms_in - start_ts_q;
    irq_d         = irq_en_q & (done_q | tflag_q);

    if (wr && addr == 3'd0) begin
      enable_d = wdata[0];
      irq_en_d = wdata[1];
    end
    if (wr && addr == 3'd5) timeout_val_d = wdata;
    if (wr && addr == 3'd1) begin
      if (wdata[1]) done_d = 1'b0;
      if (wdata[2]) tflag_d = 1'b0;
    end

    // Hardware sets below are applied after W1C so a coincident set wins.
    if (clr) begin
      state_d    = ST_IDLE;
      done_d     = 1'b0;
      tflag_d    = 1'b0;
      fired_d    = 1'b0;
      start_ts_d = '0;
      last_d     = '0;
      max_d      = '0;
      count_d    = '0;
    end else if (!enable_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_RUN;
            start_ts_d = ms_in;
            fired_d    = 1'b0;
          end
        end
        ST_RUN: begin
          if (!start && !fired_q && timeout_val_q != '0 && elapsed >= timeout_val_q) begin
            tflag_d = 1'b1;
            fired_d = 1'b1;
          end
          if (stop) begin
            last_d = elapsed;
            if (elapsed > max_q) max_d = elapsed;
            if (count_q != '1) count_d = count_q + MS_W'(1);
            done_d = 1'b1;
            if (!start) state_d = ST_IDLE;
          end
          // Start (alone or with stop) begins a fresh run using the new timestamp.
          if (start) begin
            start_ts_d = ms_in;
            fired_d    = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (rd) begin
      rdata_d = '0;
      case (addr)
        3'd0: rdata_d[1:0] = {irq_en_q, enable_q};
        3'd1: rdata_d[2:0] = {tflag_q, done_q, state_q == ST_RUN};
        3'd2: rdata_d = last_q;
        3'd3: rdata_d = max_q;
        3'd4: rdata_d = count_q;
        3'd5: rdata_d = timeout_val_q;
        3'd6: rdata_d = start_ts_q;
        default: rdata_d = ms_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      enable_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      tflag_q       <= 1'b0;
      fired_q       <= 1'b0;
      start_ts_q    <= '0;
      last_q        <= '0;
      max_q         <= '0;
      count_q       <= '0;
      timeout_val_q <= TIMEOUT_RST;
      rdata_q       <= '0;
      irq_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      enable_q      <= enable_d;
      irq_en_q      <= irq_en_d;
      done_q        <= done_d;
      tflag_q       <= tflag_d;
      fired_q       <= fired_d;
      start_ts_q    <= start_ts_d;
      last_q        <= last_d;
      max_q         <= max_d;
      count_q       <= count_d;
      timeout_val_q <= timeout_val_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_stopwatch.sv
`default_nettype none
// tb_rtc_stopwatch: directed scenarios plus randomized traffic against a
// behavioural profiler model. Rev 1.0
module tb_rtc_stopwatch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ms = '0;
  logic        start = 1'b0, stop = 1'b0, cs = 1'b0, we = 1'b0;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  rtc_stopwatch #(.MS_W(32), .TIMEOUT_RST(32'd0)) dut (
    .clk(clk), .rst(rst_n), .ms_in(ms), .start(start), .stop(stop),
    .cs(cs), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    cs = 1'b1; we = 1'b0; addr = a;
    cyc();
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    cs = 1'b1; we = 1'b1; addr = a; wdata = v;
    cyc();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic pstart();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic pstop();
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst_n = 1'b0;
    cyc(); cyc();
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %0h want 0", rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst_n = 1'b1;
    cyc();
    for (int a = 0; a < 7; a++) begin
      rd(3'(a), d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_reg%0d: got %0h want 0", a, d); end
    end
    ms = 32'h1234;
    rd(3'd7, d);
    total++; if (d !== 32'h1234) begin bad++; $display("FAIL now: got %0h want 1234", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    wr(3'd0, 32'd3);
    ms = 100; pstart();
    ms = 137; pstop();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_lag: got %b want 0", irq); end
    cyc();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_done: got %b want 1", irq); end
    rd(3'd2, d);
    total++; if (d !== 32'd37) begin bad++; $display("FAIL basic_last: got %0d want 37", d); end
    rd(3'd3, d);
    total++; if (d !== 32'd37) begin bad++; $display("FAIL basic_max: got %0d want 37", d); end
    rd(3'd4, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL basic_count: got %0d want 1", d); end
    rd(3'd1, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL basic_status: got %0h want 2", d); end
    wr(3'd1, 32'd2);
    cyc();
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_w1c: got %b want 0", irq); end
    rd(3'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL w1c_status: got %0h want 0", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    ms = 32'hFFFF_FFF0; pstart();
    ms = 32'h0000_0010; pstop();
    rd(3'd2, d);
    total++; if (d !== 32'h20) begin bad++; $display("FAIL wrap_last: got %0h want 20", d); end
    rd(3'd1, d);
    total++; if (d[0] !== 1'b0) begin bad++; $display("FAIL wrap_running: got %b want 0", d[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    wr(3'd0, 32'd7);
    ms = 1000; pstart(); ms = 1050; pstop();
    ms = 2000; pstart(); ms = 2020; pstop();
    rd(3'd2, d);
    total++; if (d !== 32'd20) begin bad++; $display("FAIL b2b_last: got %0d want 20", d); end
    rd(3'd3, d);
    total++; if (d !== 32'd50) begin bad++; $display("FAIL b2b_max: got %0d want 50", d); end
    rd(3'd4, d);
    total++; if (d !== 32'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", d); end
    ms = 3000; pstart();
    ms = 3010; start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
    rd(3'd2, d);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL b2b_last2: got %0d want 10", d); end
    rd(3'd4, d);
    total++; if (d !== 32'd3) begin bad++; $display("FAIL b2b_count2: got %0d want 3", d); end
    rd(3'd1, d);
    total++; if (d[0] !== 1'b1) begin bad++; $display("FAIL b2b_running: got %b want 1", d[0]); end
    rd(3'd6, d);
    total++; if (d !== 32'd3010) begin bad++; $display("FAIL b2b_start_ts: got %0d want 3010", d); end
  endtask

  task automatic test_timeout();
    logic [31:0] d;
    wr(3'd0, 32'd7);
    wr(3'd5, 32'd5);
    ms = 200; pstart();
    for (int t = 201; t <= 203; t++) begin ms = 32'(t); cyc(); end
    ms = 204; rd(3'd1, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL to_early204: got %0h want 1", d); end
    ms = 205; rd(3'd1, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL to_edge205: got %0h want 1", d); end
    rd(3'd1, d);
    total++; if (d !== 32'd5) begin bad++; $display("FAIL to_set: got %0h want 5", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL to_irq: got %b want 1", irq); end
    wr(3'd1, 32'd4);
    wr(3'd5, 32'd0);
    ms = 300; pstart();
    ms = 400; cyc(); cyc();
    rd(3'd1, d);
    total++; if (d !== 32'd1) begin bad++; $display("FAIL to_disabled: got %0h want 1", d); end
  endtask

  task automatic test_enable();
    logic [31:0] d;
    wr(3'd0, 32'd4);
    ms = 10; pstart(); ms = 20; pstop();
    rd(3'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL en0_status: got %0h want 0", d); end
    rd(3'd4, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL en0_count: got %0d want 0", d); end
    wr(3'd0, 32'd3);
    ms = 30; pstop();
    rd(3'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL idle_stop_status: got %0h want 0", d); end
    rd(3'd4, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL idle_stop_count: got %0d want 0", d); end
  endtask

  task automatic test_clr_and_reset();
    logic [31:0] d;
    logic [2:0]  al [7] = '{3'd2, 3'd3, 3'd4, 3'd1, 3'd5, 3'd6, 3'd0};
    ms = 50; pstart(); ms = 80; pstop();
    ms = 90; pstart();
    ms = 100; stop = 1'b1; wr(3'd0, 32'd7); stop = 1'b0;
    rd(3'd2, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_last: got %0d want 0", d); end
    rd(3'd3, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_max: got %0d want 0", d); end
    rd(3'd4, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_count: got %0d want 0", d); end
    rd(3'd1, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL clr_status: got %0h want 0", d); end
    ms = 110; pstart(); ms = 120; pstop();
    ms = 130; pstart();
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_rst_irq: got %b want 1", irq); end
    rd(3'd2, d);
    total++; if (d !== 32'd10) begin bad++; $display("FAIL pre_rst_last: got %0d want 10", d); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata: got %0h want 0", rdata); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq); end
    cyc(); rst_n = 1'b1; ms = 32'h0BAD_0000; cyc();
    foreach (al[i]) begin
      rd(al[i], d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL post_rst_reg%0d: got %0h want 0", al[i], d); end
    end
  endtask

  // Behavioural model state for the randomized scenario
  logic        m_en, m_ien, m_run, m_done, m_to, m_fired, m_irq;
  logic [31:0] m_ts, m_last, m_max, m_cnt, m_tmo, m_rdata;

  task automatic test_random();
    logic        clr, n_done, n_to;
    logic [31:0] el;
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    {m_en, m_ien, m_run, m_done, m_to, m_fired, m_irq} = '0;
    {m_ts, m_last, m_max, m_cnt, m_rdata} = '0;
    m_tmo = 32'd0;
    wr(3'd0, 32'd3);
    m_en = 1'b1; m_ien = 1'b1;
    for (int n = 0; n < 600; n++) begin
      ms    = ($urandom_range(0, 40) == 0) ? $urandom : ms + $urandom_range(0, 3);
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 6) == 0);
      cs    = ($urandom_range(0, 2) == 0);
      we    = cs && ($urandom_range(0, 3) == 0);
      addr  = 3'($urandom_range(0, 7));
      case (addr)
        3'd0:    wdata = {29'd0, $urandom_range(0, 12) == 0, 1'($urandom), $urandom_range(0, 6) != 0};
        3'd5:    wdata = $urandom_range(0, 20);
        default: wdata = $urandom;
      endcase

      m_irq = m_ien & (m_done | m_to);
      if (cs && !we) begin
        case (addr)
          3'd0: m_rdata = {30'd0, m_ien, m_en};
          3'd1: m_rdata = {29'd0, m_to, m_done, m_run};
          3'd2: m_rdata = m_last;
          3'd3: m_rdata = m_max;
          3'd4: m_rdata = m_cnt;
          3'd5: m_rdata = m_tmo;
          3'd6: m_rdata = m_ts;
          default: m_rdata = ms;
        endcase
      end
      clr    = cs && we && addr == 3'd0 && wdata[2];
      n_done = m_done && !(cs && we && addr == 3'd1 && wdata[1]);
      n_to   = m_to && !(cs && we && addr == 3'd1 && wdata[2]);
      el     = ms - m_ts;
      if (clr) begin
        {m_run, n_done, n_to, m_fired} = '0;
        {m_ts, m_last, m_max, m_cnt} = '0;
      end else if (!m_en) begin
        m_run = 1'b0;
      end else if (!m_run) begin
        if (start) begin m_run = 1'b1; m_ts = ms; m_fired = 1'b0; end
      end else begin
        if (!start && !m_fired && m_tmo != 0 && el >= m_tmo) begin n_to = 1'b1; m_fired = 1'b1; end
        if (stop) begin
          m_last = el;
          if (el > m_max) m_max = el;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          n_done = 1'b1;
          if (!start) m_run = 1'b0;
        end
        if (start) begin m_ts = ms; m_fired = 1'b0; end
      end
      m_done = n_done; m_to = n_to;
      if (cs && we && addr == 3'd0) begin m_en = wdata[0]; m_ien = wdata[1]; end
      if (cs && we && addr == 3'd5) m_tmo = wdata;

      cyc();
      total++; if (irq !== m_irq) begin bad++; $display("FAIL rnd_irq cyc%0d: got %b want %b", n, irq, m_irq); end
      if (cs && !we) begin
        total++; if (rdata !== m_rdata) begin bad++; $display("FAIL rnd_rdata cyc%0d addr%0d: got %0h want %0h", n, addr, rdata, m_rdata); end
      end
      start = 1'b0; stop = 1'b0; cs = 1'b0; we = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_timeout();
    test_enable();
    test_clr_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
